aes_kat_sequencer: RTL and testbench

AES_KAT_SEQUENCER -- requirements
Module: aes_kat_sequencer

---
 rtl/aes_kat_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_sequencer.sv
// AES known-answer-test sequencer: walks ROM vectors through an AES core.
// Optional round-trip decrypt check enabled by macro AES_KAT_DECRYPT_EN.
module aes_kat_sequencer #(
    parameter int NUM_VEC = 4,
    parameter int TIMEOUT = 64,
    localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    localparam int AW = 2 + $clog2(NUM_VEC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    mod,
    output logic [AW-1:0] rom_addr,
    input  logic [255:0]  rom_key,
    input  logic [127:0]  rom_pt,
    input  logic [127:0]  rom_ct,
    output logic          aes_start,
    output logic          aes_decrypt,
    output logic [1:0]    aes_key_len,
    output logic [255:0]  aes_key,
    output logic [127:0]  aes_din,
    input  logic          aes_done,
    input  logic [127:0]  aes_dout,
    output logic          led128,
    output logic          led192,
    output logic          led256,
    output logic          fail,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] fail_idx
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] LOAD     = 4'd2;
    localparam logic [3:0] ENC      = 4'd3;
    localparam logic [3:0] ENC_WAIT = 4'd4;
    localparam logic [3:0] DEC      = 4'd5;
    localparam logic [3:0] DEC_WAIT = 4'd6;
    localparam logic [3:0] CHECK    = 4'd7;
    localparam logic [3:0] NEXT     = 4'd8;
    localparam logic [3:0] FINISH   = 4'd9;

    logic [3:0]    state;
    logic [3:0]    nstate;
    logic [1:0]    mod_r;
    logic [1:0]    size;
    logic [IW-1:0] idx;
    logic [255:0]  key_r;
    logic [127:0]  pt_r;
    logic [127:0]  ct_r;
    logic [127:0]  din_r;
    logic [7:0]    wcnt;
    logic          vec_fail;
    logic          size_fail;
    logic          in_wait;
    logic [127:0]  exp_val;
    logic          mismatch;
    logic          tmo;
    logic          mark;
    logic          last_vec;
    logic          more_sizes;

    generate
        if (NUM_VEC > 1) begin : g_addr
            assign rom_addr = {size, idx};
        end else begin : g_addr1
            assign rom_addr = size;
        end
    endgenerate

    assign in_wait    = (state == ENC_WAIT) || (state == DEC_WAIT);
    assign exp_val    = (state == DEC_WAIT) ? pt_r : ct_r;
    assign mismatch   = in_wait && aes_done && (aes_dout != exp_val);
    assign tmo        = in_wait && !aes_done && (wcnt == 8'(TIMEOUT - 1));
    assign mark       = mismatch || tmo;
    assign last_vec   = (idx == IW'(NUM_VEC - 1));
    assign more_sizes = (mod_r == 2'b11) && (size != 2'b10);

    assign aes_start   = (state == ENC) || (state == DEC);
    assign aes_key_len = size;
    assign aes_key     = key_r;
    assign aes_din     = din_r;
    assign busy        = (state != IDLE) && (state != FINISH);
    assign done        = (state == FINISH);

`ifdef AES_KAT_DECRYPT_EN
    assign aes_decrypt = (state == DEC) || (state == DEC_WAIT);
`else
    assign aes_decrypt = 1'b0;
`endif

    // Next-state selection for the vector walk.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:     if (en) nstate = FETCH;
            FETCH:    nstate = LOAD;
            LOAD:     nstate = ENC;
            ENC:      nstate = ENC_WAIT;
            ENC_WAIT: begin
                if (aes_done) begin
`ifdef AES_KAT_DECRYPT_EN
                    nstate = DEC;
`else
                    nstate = CHECK;
`endif
                end else if (tmo) begin
                    nstate = CHECK;
                end
            end
            DEC:      nstate = DEC_WAIT;
            DEC_WAIT: if (aes_done || tmo) nstate = CHECK;
            CHECK:    nstate = NEXT;
            NEXT:     begin
                if (last_vec && !more_sizes) nstate = FINISH;
                else nstate = FETCH;
            end
            FINISH:   if (!en) nstate = IDLE;
            default:  nstate = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nstate;
    end

    // Vector datapath: mode, index, captured ROM data, wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_r     <= 2'b00;
            size      <= 2'b00;
            idx       <= '0;
            key_r     <= '0;
            pt_r      <= '0;
            ct_r      <= '0;
            din_r     <= '0;
            wcnt      <= '0;
            vec_fail  <= 1'b0;
            size_fail <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        mod_r     <= mod;
                        size      <= (mod == 2'b11) ? 2'b00 : mod;
                        idx       <= '0;
                        size_fail <= 1'b0;
                    end
                end
                LOAD: begin
                    key_r    <= rom_key;
                    pt_r     <= rom_pt;
                    ct_r     <= rom_ct;
                    din_r    <= rom_pt;
                    vec_fail <= 1'b0;
                    wcnt     <= '0;
                end
                ENC, DEC: wcnt <= 8'd1;
                ENC_WAIT: begin
                    if (aes_done) din_r <= ct_r;
                    else wcnt <= wcnt + 8'd1;
                end
                DEC_WAIT: if (!aes_done) wcnt <= wcnt + 8'd1;
                CHECK: size_fail <= size_fail | vec_fail;
                NEXT: begin
                    if (last_vec) begin
                        idx       <= '0;
                        size      <= size + 2'd1;
                        size_fail <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
            if (mark) vec_fail <= 1'b1;
        end
    end

    // Sticky status: per-size pass LEDs and first-failure capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led128   <= 1'b0;
            led192   <= 1'b0;
            led256   <= 1'b0;
            fail     <= 1'b0;
            fail_idx <= '0;
        end else if (state == IDLE) begin
            if (en) begin
                led128   <= 1'b0;
                led192   <= 1'b0;
                led256   <= 1'b0;
                fail     <= 1'b0;
                fail_idx <= '0;
            end
        end else begin
            if (state == NEXT && last_vec && !size_fail) begin
                case (size)
                    2'b00:   led128 <= 1'b1;
                    2'b01:   led192 <= 1'b1;
                    2'b10:   led256 <= 1'b1;
                    default: ;
                endcase
            end
            if (mark && !fail) begin
                fail     <= 1'b1;
                fail_idx <= rom_addr;
            end
        end
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed bench for aes_kat_sequencer with a ROM and a toy AES core model.
// Honours AES_KAT_DECRYPT_EN for pulse counts and the round-trip scenario.
module tb_aes_kat_sequencer;

    localparam int NV  = 4;
    localparam int TO  = 64;
    localparam int AW  = 4;
    localparam int LAT = 10;
`ifdef AES_KAT_DECRYPT_EN
    localparam int PPV = 2;
`else
    localparam int PPV = 1;
`endif
    localparam logic [127:0] MASK = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mod = 2'b00;
    logic [AW-1:0] rom_addr;
    logic [255:0]  rom_key = '0;
    logic [127:0]  rom_pt = '0;
    logic [127:0]  rom_ct = '0;
    logic          aes_start;
    logic          aes_decrypt;
    logic [1:0]    aes_key_len;
    logic [255:0]  aes_key;
    logic [127:0]  aes_din;
    logic          aes_done;
    logic [127:0]  aes_dout;
    logic          led128, led192, led256;
    logic          fail, busy, done;
    logic [AW-1:0] fail_idx;

    int total = 0;
    int bad = 0;

    aes_kat_sequencer #(.NUM_VEC(NV), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .en(en), .mod(mod),
        .rom_addr(rom_addr), .rom_key(rom_key),
        .rom_pt(rom_pt), .rom_ct(rom_ct),
        .aes_start(aes_start), .aes_decrypt(aes_decrypt),
        .aes_key_len(aes_key_len), .aes_key(aes_key),
        .aes_din(aes_din), .aes_done(aes_done),
        .aes_dout(aes_dout), .led128(led128),
        .led192(led192), .led256(led256), .fail(fail),
        .busy(busy), .done(done), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] key_of(input logic [3:0] a);
        key_of = {8{24'hC0FFEE, 4'h0, a}};
    endfunction

    function automatic logic [127:0] pt_of(input logic [3:0] a);
        pt_of = {4{28'h1234567, a}};
    endfunction

    function automatic logic [127:0] xf(input logic [255:0] k,
                                        input logic [127:0] d);
        xf = d ^ k[127:0] ^ MASK;
    endfunction

    // Vector ROM, one-cycle read latency.
    always @(posedge clk) begin
        rom_key <= key_of(rom_addr);
        rom_pt  <= pt_of(rom_addr);
        rom_ct  <= xf(key_of(rom_addr), pt_of(rom_addr));
    end

    // Toy AES core; deliberately ignores the DUT reset.
    bit           never_done = 1'b0;
    int           corrupt_a = -1;
    int           dcorrupt_a = -1;
    logic         inj_done = 1'b0;
    logic         mdone = 1'b0;
    logic [127:0] mdout = '0;
    logic         act = 1'b0;
    int           cnt = 0;
    logic [255:0] ck = '0;
    logic [127:0] cd = '0;
    logic         cdec = 1'b0;
    int           starts = 0;
    logic [3:0]   last_a = '0;
    bit           len_bad = 1'b0;

    assign aes_done = mdone | inj_done;
    assign aes_dout = mdout;

    always @(posedge clk) begin
        mdone <= 1'b0;
        if (aes_start) begin
            act    <= 1'b1;
            cnt    <= LAT;
            ck     <= aes_key;
            cd     <= aes_din;
            cdec   <= aes_decrypt;
            starts <= starts + 1;
            last_a <= aes_key[3:0];
            if (aes_key_len != aes_key[3:2]) len_bad <= 1'b1;
        end else if (act) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                act <= 1'b0;
                if (!never_done) begin
                    mdone <= 1'b1;
                    if ((!cdec && int'(ck[3:0]) == corrupt_a) ||
                        (cdec && int'(ck[3:0]) == dcorrupt_a))
                        mdout <= xf(ck, cd) ^ 128'h1;
                    else
                        mdout <= xf(ck, cd);
                end
            end
        end
    end

    int s0, r128, r192, r256, first_start, fail_cyc;

    task automatic run_seq(input logic [1:0] m, input bit drop_en,
                           output bit to);
        r128 = -1; r192 = -1; r256 = -1;
        first_start = -1; fail_cyc = -1;
        s0 = starts;
        to = 1'b1;
        @(negedge clk);
        mod = m;
        en  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (drop_en && i == 2) en = 1'b0;
            if (aes_start && first_start < 0) first_start = i;
            if (fail && fail_cyc < 0) fail_cyc = i;
            if (led128 && r128 < 0) r128 = starts - s0;
            if (led192 && r192 < 0) r192 = starts - s0;
            if (led256 && r256 < 0) r256 = starts - s0;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic end_run();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%0b want=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%0b want=0", done);
        end
        total++;
        if ({led128, led192, led256} !== 3'b000) begin
            bad++;
            $display("FAIL rst_leds got=%0b%0b%0b want=000",
                     led128, led192, led256);
        end
        total++;
        if (fail !== 1'b0 || fail_idx !== 4'h0) begin
            bad++;
            $display("FAIL rst_fail got=%0b/%0h want=0/0", fail, fail_idx);
        end
        total++;
        if (aes_start !== 1'b0 || aes_decrypt !== 1'b0) begin
            bad++;
            $display("FAIL rst_start got=%0b%0b want=00",
                     aes_start, aes_decrypt);
        end
        total++;
        if (aes_key !== 256'h0 || aes_din !== 128'h0 ||
            aes_key_len !== 2'b00 || rom_addr !== 4'h0) begin
            bad++;
            $display("FAIL rst_data got=key%0h din%0h len%0h addr%0h want=0",
                     aes_key, aes_din, aes_key_len, rom_addr);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mod128();
        bit to;
        run_seq(2'b00, 1'b0, to);
        total++;
        if (to !== 1'b0) begin
            bad++; $display("FAIL m128_timeout got=1 want=0");
        end
        total++;
        if ({led128, led192, led256} !== 3'b100) begin
            bad++;
            $display("FAIL m128_leds got=%0b%0b%0b want=100",
                     led128, led192, led256);
        end
        total++;
        if (fail !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL m128_status got=fail%0b done%0b want=fail0 done1",
                     fail, done);
        end
        total++;
        if (starts - s0 != 4 * PPV) begin
            bad++;
            $display("FAIL m128_starts got=%0d want=%0d", starts - s0, 4 * PPV);
        end
        total++;
        if (last_a !== 4'h3 || len_bad !== 1'b0) begin
            bad++;
            $display("FAIL m128_addr got=%0h/%0b want=3/0", last_a, len_bad);
        end
        end_run();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL m128_idle got=done%0b busy%0b want=0/0", done, busy);
        end
    endtask

    task automatic test_all_sizes();
        bit to;
        run_seq(2'b11, 1'b0, to);
        total++;
        if (to !== 1'b0) begin
            bad++; $display("FAIL all_timeout got=1 want=0");
        end
        total++;
        if (r128 != 4 * PPV || r192 != 8 * PPV || r256 != 12 * PPV) begin
            bad++;
            $display("FAIL all_led_order got=%0d,%0d,%0d want=%0d,%0d,%0d",
                     r128, r192, r256, 4 * PPV, 8 * PPV, 12 * PPV);
        end
        total++;
        if (starts - s0 != 12 * PPV || fail !== 1'b0) begin
            bad++;
            $display("FAIL all_count got=%0d fail%0b want=%0d fail0",
                     starts - s0, fail, 12 * PPV);
        end
        total++;
        if (last_a !== 4'hB || len_bad !== 1'b0) begin
            bad++;
            $display("FAIL all_addr got=%0h/%0b want=b/0", last_a, len_bad);
        end
        end_run();
    endtask

    task automatic test_drop_en();
        bit to;
        run_seq(2'b10, 1'b1, to);
        total++;
        if (to !== 1'b0) begin
            bad++; $display("FAIL drop_timeout got=1 want=0");
        end
        total++;
        if ({led128, led192, led256} !== 3'b001) begin
            bad++;
            $display("FAIL drop_leds got=%0b%0b%0b want=001",
                     led128, led192, led256);
        end
        total++;
        if (starts - s0 != 4 * PPV) begin
            bad++;
            $display("FAIL drop_starts got=%0d want=%0d",
                     starts - s0, 4 * PPV);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle got=done%0b busy%0b want=0/0", done, busy);
        end
    endtask

    task automatic test_corrupt();
        bit to;
        corrupt_a = 6;
        run_seq(2'b01, 1'b0, to);
        total++;
        if (to !== 1'b0) begin
            bad++; $display("FAIL corr_timeout got=1 want=0");
        end
        total++;
        if ({led128, led192, led256} !== 3'b000) begin
            bad++;
            $display("FAIL corr_leds got=%0b%0b%0b want=000",
                     led128, led192, led256);
        end
        total++;
        if (fail !== 1'b1 || fail_idx !== 4'h6) begin
            bad++;
            $display("FAIL corr_idx got=%0b/%0h want=1/6", fail, fail_idx);
        end
        total++;
        if (last_a !== 4'h7 || starts - s0 != 4 * PPV) begin
            bad++;
            $display("FAIL corr_rest got=%0h/%0d want=7/%0d",
                     last_a, starts - s0, 4 * PPV);
        end
        corrupt_a = -1;
        end_run();
    endtask

    task automatic test_timeout();
        bit to;
        never_done = 1'b1;
        run_seq(2'b00, 1'b0, to);
        total++;
        if (to !== 1'b0) begin
            bad++; $display("FAIL tmo_complete got=1 want=0");
        end
        total++;
        if (first_start < 0 || fail_cyc - first_start != TO) begin
            bad++;
            $display("FAIL tmo_latency got=%0d want=%0d",
                     fail_cyc - first_start, TO);
        end
        total++;
        if (fail !== 1'b1 || fail_idx !== 4'h0 || led128 !== 1'b0) begin
            bad++;
            $display("FAIL tmo_status got=%0b/%0h/%0b want=1/0/0",
                     fail, fail_idx, led128);
        end
        total++;
        if (starts - s0 != 4) begin
            bad++;
            $display("FAIL tmo_starts got=%0d want=4", starts - s0);
        end
        never_done = 1'b0;
        end_run();
    endtask

    task automatic test_reset_mid();
        int s1;
        bit hit;
        bit moved;
        s0 = starts;
        hit = 1'b0;
        @(negedge clk);
        mod = 2'b00;
        en  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (starts - s0 >= 1 + PPV) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL rmid_reach got=0 want=1");
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || aes_start !== 1'b0 || done !== 1'b0 ||
            fail !== 1'b0 || {led128, led192, led256} !== 3'b000) begin
            bad++;
            $display("FAIL rmid_async got=busy%0b start%0b done%0b fail%0b want=0",
                     busy, aes_start, done, fail);
        end
        s1 = starts;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || aes_start || done || fail) moved = 1'b1;
        end
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        if (busy || done || fail) moved = 1'b1;
        total++;
        if (moved !== 1'b0 || starts != s1) begin
            bad++;
            $display("FAIL rmid_stale got=moved%0b starts%0d want=0/%0d",
                     moved, starts, s1);
        end
        total++;
        if (fail_idx !== 4'h0 || {led128, led192, led256} !== 3'b000) begin
            bad++;
            $display("FAIL rmid_outs got=%0h want=0", fail_idx);
        end
    endtask

`ifdef AES_KAT_DECRYPT_EN
    task automatic test_decrypt();
        bit to;
        dcorrupt_a = 0;
        run_seq(2'b00, 1'b0, to);
        total++;
        if (to !== 1'b0 || fail !== 1'b1 || fail_idx !== 4'h0) begin
            bad++;
            $display("FAIL dec_rt got=to%0b fail%0b idx%0h want=0/1/0",
                     to, fail, fail_idx);
        end
        total++;
        if (led128 !== 1'b0 || starts - s0 != 8) begin
            bad++;
            $display("FAIL dec_rest got=led%0b starts%0d want=0/8",
                     led128, starts - s0);
        end
        dcorrupt_a = -1;
        end_run();
    endtask
`endif

    initial begin
        test_reset();
        test_mod128();
        test_all_sizes();
        test_drop_en();
        test_corrupt();
        test_timeout();
        test_reset_mid();
`ifdef AES_KAT_DECRYPT_EN
        test_decrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
